// File: rtl/card_selector_if.sv
// rtl/card_selector_if.sv - player input and board status bundle for card_selector
interface card_selector_if;
  logic        board_ld;
  logic [47:0] board_data;
  logic        mv_up;
  logic        mv_down;
  logic        mv_left;
  logic        mv_right;
  logic        sel;
  logic        turn_clr;
  logic [3:0]  cursor;
  logic [1:0]  sel_count;
  logic [15:0] faceup_mask;
  logic [15:0] matched_mask;
  logic        match_valid;
  logic        match;
  logic [3:0]  pair_count;
  logic        all_matched;

  modport master (
    output board_ld, board_data, mv_up, mv_down, mv_left, mv_right, sel, turn_clr,
    input  cursor, sel_count, faceup_mask, matched_mask, match_valid, match,
           pair_count, all_matched
  );

  modport slave (
    input  board_ld, board_data, mv_up, mv_down, mv_left, mv_right, sel, turn_clr,
    output cursor, sel_count, faceup_mask, matched_mask, match_valid, match,
           pair_count, all_matched
  );
endinterface

// File: rtl/card_selector.sv
// rtl/card_selector.sv - memory-game board, cursor and pair compare; CARD_SEL_WRAP_EN makes the cursor wrap
module card_selector #(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input logic            clk,
  input logic            rst,
  card_selector_if.slave bus
);
  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_WAIT_FIRST  = 3'd1;
  localparam logic [2:0] S_WAIT_SECOND = 3'd2;
  localparam logic [2:0] S_HOLD        = 3'd3;
  localparam logic [2:0] S_COMPARE     = 3'd4;
  localparam logic [2:0] S_DONE        = 3'd5;

  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);

  logic [2:0]    state;
  logic [47:0]   board;
  logic [3:0]    cursor;
  logic [3:0]    first_idx;
  logic [3:0]    second_idx;
  logic [TW-1:0] timer;
  logic [1:0]    sel_count;
  logic [15:0]   faceup_mask;
  logic [15:0]   matched_mask;
  logic          match_valid;
  logic          match;
  logic [3:0]    pair_count;

  logic [1:0]    row;
  logic [1:0]    col;
  logic [3:0]    cursor_nxt;
  logic          move_ok;
  logic          cur_eligible;
  logic [2:0]    first_id;
  logic [2:0]    second_id;
  logic          ids_equal;
  logic [3:0]    pair_count_inc;

  // Conflicting move pulses in one cycle cancel each other out.
  assign move_ok        = $onehot({bus.mv_up, bus.mv_down, bus.mv_left, bus.mv_right});
  assign cur_eligible   = !faceup_mask[cursor] && !matched_mask[cursor];
  assign first_id       = board[int'(first_idx) * 3 +: 3];
  assign second_id      = board[int'(second_idx) * 3 +: 3];
  assign ids_equal      = (first_id == second_id);
  assign pair_count_inc = pair_count + 4'd1;

  // Candidate cursor position for a single move pulse (wrap or saturate at edges).
  always_comb begin
    row = cursor[3:2];
    col = cursor[1:0];
`ifdef CARD_SEL_WRAP_EN
    if (bus.mv_up)         row = row - 2'd1;
    else if (bus.mv_down)  row = row + 2'd1;
    else if (bus.mv_left)  col = col - 2'd1;
    else if (bus.mv_right) col = col + 2'd1;
`else
    if (bus.mv_up && row != 2'd0)         row = row - 2'd1;
    else if (bus.mv_down && row != 2'd3)  row = row + 2'd1;
    else if (bus.mv_left && col != 2'd0)  col = col - 2'd1;
    else if (bus.mv_right && col != 2'd3) col = col + 2'd1;
`endif
    cursor_nxt = {row, col};
  end

  // Turn state machine: board load, cursor, flips, reveal timer and pair verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      board        <= '0;
      cursor       <= '0;
      first_idx    <= '0;
      second_idx   <= '0;
      timer        <= '0;
      sel_count    <= '0;
      faceup_mask  <= '0;
      matched_mask <= '0;
      match_valid  <= 1'b0;
      match        <= 1'b0;
      pair_count   <= '0;
    end else begin
      match_valid <= 1'b0;
      if (bus.board_ld) begin
        board        <= bus.board_data;
        faceup_mask  <= '0;
        matched_mask <= '0;
        sel_count    <= '0;
        pair_count   <= '0;
        match        <= 1'b0;
        timer        <= '0;
        cursor       <= '0;
        state        <= S_WAIT_FIRST;
      end else begin
        case (state)
          S_WAIT_FIRST: begin
            // turn_clr is a no-op here but still shadows sel and moves
            if (bus.turn_clr) begin
            end else if (bus.sel) begin
              if (cur_eligible) begin
                faceup_mask[cursor] <= 1'b1;
                first_idx           <= cursor;
                sel_count           <= 2'd1;
                state               <= S_WAIT_SECOND;
              end
            end else if (move_ok) begin
              cursor <= cursor_nxt;
            end
          end
          S_WAIT_SECOND: begin
            if (bus.turn_clr) begin
              faceup_mask[first_idx] <= 1'b0;
              sel_count              <= 2'd0;
              state                  <= S_WAIT_FIRST;
            end else if (bus.sel) begin
              if (cur_eligible && cursor != first_idx) begin
                faceup_mask[cursor] <= 1'b1;
                second_idx          <= cursor;
                sel_count           <= 2'd2;
                timer               <= '0;
                state               <= S_HOLD;
              end
            end else if (move_ok) begin
              cursor <= cursor_nxt;
            end
          end
          S_HOLD: begin
            timer <= timer + 1'b1;
            if (timer == HOLD_LAST) state <= S_COMPARE;
          end
          S_COMPARE: begin
            match_valid             <= 1'b1;
            match                   <= ids_equal;
            faceup_mask[first_idx]  <= 1'b0;
            faceup_mask[second_idx] <= 1'b0;
            sel_count               <= 2'd0;
            if (ids_equal) begin
              matched_mask[first_idx]  <= 1'b1;
              matched_mask[second_idx] <= 1'b1;
              pair_count               <= pair_count_inc;
            end
            state <= (ids_equal && pair_count_inc == 4'd8) ? S_DONE : S_WAIT_FIRST;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.cursor       = cursor;
  assign bus.sel_count    = sel_count;
  assign bus.faceup_mask  = faceup_mask;
  assign bus.matched_mask = matched_mask;
  assign bus.match_valid  = match_valid;
  assign bus.match        = match;
  assign bus.pair_count   = pair_count;
  assign bus.all_matched  = (state == S_DONE);
endmodule

// File: tb/tb_card_selector.sv
// tb/tb_card_selector.sv - directed self-checking bench for card_selector
module tb_card_selector;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  int m_row = 0;
  int m_col = 0;
  logic [47:0] brd;
  logic [15:0] acc;
  logic saw_mv;

  always #5 clk = ~clk;

  card_selector_if bus();

  card_selector #(.HOLD_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.board_ld = 1'b0; bus.board_data = '0;
    bus.mv_up = 1'b0; bus.mv_down = 1'b0; bus.mv_left = 1'b0; bus.mv_right = 1'b0;
    bus.sel = 1'b0; bus.turn_clr = 1'b0;
  endtask

  task automatic mv(input logic u, input logic d, input logic l, input logic r);
    bus.mv_up = u; bus.mv_down = d; bus.mv_left = l; bus.mv_right = r;
    step();
    bus.mv_up = 1'b0; bus.mv_down = 1'b0; bus.mv_left = 1'b0; bus.mv_right = 1'b0;
  endtask

  task automatic sel_pulse();
    bus.sel = 1'b1; step(); bus.sel = 1'b0;
  endtask

  task automatic clr_pulse();
    bus.turn_clr = 1'b1; step(); bus.turn_clr = 1'b0;
  endtask

  task automatic load(input logic [47:0] b);
    bus.board_data = b; bus.board_ld = 1'b1; step(); bus.board_ld = 1'b0;
    m_row = 0; m_col = 0;
  endtask

  task automatic goto(input int k);
    for (int n = 0; n < 4; n++) begin
      if (m_row < k / 4) begin mv(1'b0, 1'b1, 1'b0, 1'b0); m_row++; end
      else if (m_row > k / 4) begin mv(1'b1, 1'b0, 1'b0, 1'b0); m_row--; end
    end
    for (int n = 0; n < 4; n++) begin
      if (m_col < k % 4) begin mv(1'b0, 1'b0, 1'b0, 1'b1); m_col++; end
      else if (m_col > k % 4) begin mv(1'b0, 1'b0, 1'b1, 1'b0); m_col--; end
    end
    chk("goto_cursor", bus.cursor, k);
  endtask

  task automatic flip_pair(input int a, input int b, input logic exp_m,
                           input logic [15:0] exp_matched, input logic [3:0] exp_pc);
    goto(a); sel_pulse();
    chk("first_sel_count", bus.sel_count, 1);
    goto(b); sel_pulse();
    chk("second_sel_count", bus.sel_count, 2);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_no_valid", bus.match_valid, 0);
    end
    step();
    chk("cmp_valid", bus.match_valid, 1);
    chk("cmp_match", bus.match, exp_m);
    chk("cmp_matched", bus.matched_mask, exp_matched);
    chk("cmp_faceup", bus.faceup_mask, 0);
    chk("cmp_pairs", bus.pair_count, exp_pc);
    chk("cmp_sel_count", bus.sel_count, 0);
  endtask

  initial begin
    clr_in();
    #1 rst = 1'b1;
    #2;
    chk("rst_cursor", bus.cursor, 0);
    chk("rst_sel_count", bus.sel_count, 0);
    chk("rst_faceup", bus.faceup_mask, 0);
    chk("rst_matched", bus.matched_mask, 0);
    chk("rst_valid", bus.match_valid, 0);
    chk("rst_match", bus.match, 0);
    chk("rst_pairs", bus.pair_count, 0);
    chk("rst_done", bus.all_matched, 0);
    #10 rst = 1'b0;
    step();

    // board A: cards 0,1 id 5; card 2 id 1; card 3 id 2; rest id 0
    brd = '0;
    brd[2:0] = 3'd5; brd[5:3] = 3'd5; brd[8:6] = 3'd1; brd[11:9] = 3'd2;
    load(brd);
    chk("ld_cursor", bus.cursor, 0);

    // matching pair with exact compare latency, verdict held afterwards
    flip_pair(0, 1, 1'b1, 16'h0003, 4'd1);
    step();
    chk("valid_one_cycle", bus.match_valid, 0);
    chk("match_held", bus.match, 1);

    // illegal selects: matched card, then the same card twice
    goto(0); sel_pulse();
    chk("sel_matched_ignored", bus.sel_count, 0);
    chk("sel_matched_faceup", bus.faceup_mask, 0);
    goto(2); sel_pulse(); sel_pulse();
    chk("double_sel_count", bus.sel_count, 1);
    chk("double_sel_faceup", bus.faceup_mask, 16'h0004);

    // turn_clr in WAIT_SECOND, then as a no-op in WAIT_FIRST
    clr_pulse();
    chk("clr_faceup", bus.faceup_mask, 0);
    chk("clr_sel_count", bus.sel_count, 0);
    goto(6); sel_pulse();
    chk("card6_up", bus.faceup_mask, 16'h0040);
    clr_pulse();
    chk("clr6_faceup", bus.faceup_mask, 0);
    chk("clr6_sel_count", bus.sel_count, 0);
    clr_pulse();
    chk("clr_wf_noop", bus.sel_count, 0);

    // mismatch with turn_clr asserted during HOLD: compare still happens
    goto(2); sel_pulse(); goto(3); sel_pulse();
    chk("mis_faceup", bus.faceup_mask, 16'h000C);
    step();
    bus.turn_clr = 1'b1; step(); bus.turn_clr = 1'b0;
    step(); step();
    chk("mis_hold_valid", bus.match_valid, 0);
    step();
    chk("mis_valid", bus.match_valid, 1);
    chk("mis_match", bus.match, 0);
    chk("mis_faceup_clr", bus.faceup_mask, 0);
    chk("mis_matched", bus.matched_mask, 16'h0003);
    chk("mis_pairs", bus.pair_count, 1);
    sel_pulse();
    chk("mis_back_wf", bus.faceup_mask, 16'h0008);
    clr_pulse();

    // cursor edges: col 3 + mv_right, conflicting moves, sel beats move
    mv(1'b0, 1'b0, 1'b0, 1'b1);
`ifdef CARD_SEL_WRAP_EN
    m_col = 0;
    chk("edge_right", bus.cursor, 0);
`else
    chk("edge_right", bus.cursor, 3);
`endif
    mv(1'b1, 1'b0, 1'b1, 1'b0);
    chk("multi_move", bus.cursor, m_row * 4 + m_col);
    bus.sel = 1'b1; bus.mv_down = 1'b1; step(); bus.sel = 1'b0; bus.mv_down = 1'b0;
    chk("sel_over_move_cursor", bus.cursor, m_row * 4 + m_col);
`ifdef CARD_SEL_WRAP_EN
    chk("sel_over_move_count", bus.sel_count, 0);
`else
    chk("sel_over_move_count", bus.sel_count, 1);
`endif
    clr_pulse();

    // board B: card i and card i+8 share id i
    for (int i = 0; i < 16; i++) brd[i*3 +: 3] = 3'(i % 8);
    load(brd);
    chk("ldB_pairs", bus.pair_count, 0);
    chk("ldB_matched", bus.matched_mask, 0);
    acc = '0;
    for (int p = 0; p < 8; p++) begin
      acc[p] = 1'b1; acc[p+8] = 1'b1;
      if (p == 7) chk("not_done_yet", bus.all_matched, 0);
      flip_pair(p, p + 8, 1'b1, acc, 4'(p + 1));
    end
    chk("done_all_matched", bus.all_matched, 1);
    chk("done_pairs", bus.pair_count, 8);
    sel_pulse();
    mv(1'b1, 1'b0, 1'b0, 1'b0);
    chk("done_cursor_frozen", bus.cursor, 15);
    chk("done_sel_frozen", bus.sel_count, 0);
    chk("done_still", bus.all_matched, 1);
    load(brd);
    chk("reld_pairs", bus.pair_count, 0);
    chk("reld_matched", bus.matched_mask, 0);
    chk("reld_done", bus.all_matched, 0);
    chk("reld_cursor", bus.cursor, 0);
    chk("reld_match", bus.match, 0);
    sel_pulse();
    chk("reld_wait_first", bus.sel_count, 1);

    // asynchronous reset in the middle of HOLD
    goto(8); sel_pulse();
    chk("pre_rst_count", bus.sel_count, 2);
    step(); step();
    #2 rst = 1'b1;
    #1;
    chk("arst_cursor", bus.cursor, 0);
    chk("arst_faceup", bus.faceup_mask, 0);
    chk("arst_sel_count", bus.sel_count, 0);
    chk("arst_valid", bus.match_valid, 0);
    step();
    #2 rst = 1'b0;
    saw_mv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.match_valid !== 1'b0) saw_mv = 1'b1;
    end
    chk("no_valid_after_rst", saw_mv, 0);
    chk("idle_after_rst_count", bus.sel_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/card_selector.md
Name: card_selector

Overview:
Upstream stage of the memory-game turn FSM. Owns the 4x4 board of 16 cards (8 pairs, 3-bit pair id per card) and the player cursor. Turns debounced move/select pulses into card flips. Produces the selected-card count, the face-up and matched masks, and a one-cycle match verdict per turn. The turn FSM consumes these and issues turn_clr on timeout or turn change.

Parameters:
HOLD_CYCLES, 50_000_000, cycles both flipped cards stay revealed before compare (>=1; 1 s at 50 MHz)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
board_ld  in  1  pulse: latch new board, start game
board_data  in  48  card i pair id = board_data[3i+2:3i]
mv_up  in  1  pulse: cursor row-1
mv_down  in  1  pulse: cursor row+1
mv_left  in  1  pulse: cursor col-1
mv_right  in  1  pulse: cursor col+1
sel  in  1  pulse: flip card under cursor
turn_clr  in  1  pulse from turn FSM: abort current selection
cursor  out  4  {row[1:0], col[1:0]}
sel_count  out  2  cards currently selected this turn (0/1/2)
faceup_mask  out  16  bit i = card i revealed, unmatched
matched_mask  out  16  bit i = card i permanently matched
match_valid  out  1  one-cycle strobe, verdict ready
match  out  1  verdict, valid with match_valid, held until next strobe
pair_count  out  4  pairs matched this game (0..8)
all_matched  out  1  high in DONE

Behaviour:
- Reset: rst is asynchronous, active-high; clock clk. All outputs, board, counters, and first/second index cleared to 0. State goes to IDLE.
- States: IDLE, WAIT_FIRST, WAIT_SECOND, HOLD, COMPARE, DONE.
- Input priority per cycle: board_ld > turn_clr > sel > moves. A lower-priority input in the same cycle is dropped, not queued.
- board_ld, any state:
  - latch board_data;
  - clear faceup_mask, matched_mask, sel_count, pair_count, match, timer;
  - cursor=0; next state WAIT_FIRST.
- Moves: accepted only in WAIT_FIRST/WAIT_SECOND. If more than one mv_* is high in a cycle, all are ignored. At an edge the cursor saturates (no change).
- sel in WAIT_FIRST:
  - if the cursor card is neither face-up nor matched: set its faceup bit, first_idx=cursor, sel_count=1, go to WAIT_SECOND;
  - else ignored.
- sel in WAIT_SECOND:
  - if the cursor card is eligible and cursor!=first_idx: set faceup bit, second_idx=cursor, sel_count=2, timer=0, go to HOLD;
  - else ignored.
- HOLD: timer increments each cycle. On timer==HOLD_CYCLES-1, go to COMPARE. sel, moves, and turn_clr are ignored.
- COMPARE, exactly one cycle:
  - match_valid=1; match = (id[first_idx]==id[second_idx]);
  - on match: set both matched bits, pair_count+1;
  - always: clear both faceup bits, sel_count=0;
  - next state DONE if the post-update pair_count==8, else WAIT_FIRST.
- Timing: match_valid asserts HOLD_CYCLES+1 cycles after the accepting sel edge. Masks and sel_count update on the same edge as the match_valid strobe.
- turn_clr:
  - in WAIT_SECOND: clear first card's faceup bit, sel_count=0, go to WAIT_FIRST;
  - in WAIT_FIRST: no-op;
  - in HOLD/COMPARE/IDLE/DONE: ignored.
- DONE: all_matched=1. Only board_ld or rst leaves DONE.
- Duplicate ids: the board is not validated; comparison is purely by id.
- Reset mid-HOLD: everything is lost immediately; no match_valid is issued.

Optional Feature:
- Macro: CARD_SEL_WRAP_EN.
- Defined: the cursor wraps at edges, modulo 4 per axis. Example: col 3 + mv_right gives col 0, row unchanged; row 0 + mv_up gives row 3.
- Undefined: the cursor saturates at edges as specified above.

Test Plan:
1. Matching pair, HOLD_CYCLES=4: board_ld with card0=card1=id 5; sel at 0, mv_right, sel at 1 -> sel_count goes 1 then 2. match_valid=1, match=1 exactly 5 cycles after the second sel. matched_mask=0x0003, faceup_mask=0, pair_count=1.
2. Mismatch: card0 id 1, card1 id 2; flip both -> match=0, faceup_mask returns to 0, matched_mask=0, state WAIT_FIRST.
3. Illegal selects: sel twice on cursor 0 -> second sel ignored, sel_count stays 1. After pair 0/1 is matched, sel on card 0 -> ignored.
4. turn_clr in WAIT_SECOND with card 6 up -> faceup_mask=0, sel_count=0. turn_clr during HOLD -> compare still occurs.
5. Full game: match all 8 pairs -> pair_count=8, all_matched=1. Further sel/moves have no effect. board_ld -> all cleared, WAIT_FIRST.
6. Edges: cursor=3, mv_right -> 3 without the macro, 0 with CARD_SEL_WRAP_EN. mv_up and mv_left in the same cycle -> cursor unchanged. rst asserted mid-HOLD -> all outputs 0 asynchronously.
